// File: rtl/sipo_frame_pkg.sv
// Shared FSM encoding and line-level constants for the framed serial receiver.
package sipo_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register with selectable direction and running parity.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] value,
  output logic             parity
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value  <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      value  <= '0;
      parity <= 1'b0;
    end else if (shift) begin
      parity <= parity ^ din;
      // first bit ends up at the far end once WIDTH bits have been shifted
      if (MSB_FIRST != 0) value <= {value[WIDTH-2:0], din};
      else                value <= {din, value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start/data/parity/stop FSM feeding a one-word valid/ready output.
module sipo_frame_rx
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             bit_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  state_t          state, next;
  logic [CW-1:0]   cnt;
  logic            par_bad;
  logic            clr, shift;
  logic            good, perr_evt, ferr_evt, ovr_evt;
  logic            perr_q, ferr_q, ovr_q;
  logic [WIDTH-1:0] word;
  logic            run_par;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift (shift),
    .din   (din),
    .value (word),
    .parity(run_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    clr      = 1'b0;
    shift    = 1'b0;
    good     = 1'b0;
    perr_evt = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bit_en && din == START_LVL) begin
          clr  = 1'b1;
          next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_en) begin
          shift = 1'b1;
          if (cnt == CW'(WIDTH - 1))
            next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_en) next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_en) begin
          if (din == STOP_LVL) begin
            if (par_bad) perr_evt = 1'b1;
            else         good     = 1'b1;
            next = ST_IDLE;
          end else begin
            ferr_evt = 1'b1;
            next     = ST_BREAK_WAIT;
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (bit_en && din == LINE_IDLE) next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  assign ovr_evt = good && dout_valid && !dout_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      par_bad <= 1'b0;
    end else begin
      if (clr) begin
        cnt     <= '0;
        par_bad <= 1'b0;
      end else if (shift) begin
        cnt <= cnt + CW'(1);
      end
      if (state == ST_PARITY && bit_en)
        par_bad <= (din != run_par);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (good && (!dout_valid || dout_ready)) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // two-stage pulse path: event latched on the sampling edge, output one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      perr_q     <= perr_evt;
      ferr_q     <= ferr_evt;
      ovr_q      <= ovr_evt;
      parity_err <= perr_q;
      frame_err  <= ferr_q;
      overrun    <= ovr_q;
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed scoreboard bench for sipo_frame_rx (8-bit, even parity) plus an LSB-first instance.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst, din, bit_en, dout_ready;
  logic [7:0] dout, lsb_dout;
  logic       dout_valid, busy, parity_err, frame_err, overrun;
  logic       lsb_valid, lsb_busy, lsb_perr, lsb_ferr, lsb_ovr;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb_q[$];
  logic       m_valid;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .bit_en(bit_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .bit_en(bit_en),
    .dout(lsb_dout), .dout_valid(lsb_valid), .dout_ready(dout_ready),
    .busy(lsb_busy), .parity_err(lsb_perr), .frame_err(lsb_ferr), .overrun(lsb_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; one strobe then three idle cycles
  task automatic send_bit(input logic b);
    din    = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] word, input logic par,
                            input logic stop, input logic rdy);
    logic       par_ok, e_perr, e_ferr, e_ovr;
    logic [7:0] exp_w;
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(word[i]);
    send_bit(par);
    par_ok = (par == ^word);
    e_perr = stop && !par_ok;
    e_ferr = !stop;
    e_ovr  = stop && par_ok && m_valid && !rdy;
    if (stop && par_ok && (!m_valid || rdy)) begin
      sb_q.push_back(word);
      m_valid = 1'b1;
      m_dout  = word;
    end
    din        = stop;
    bit_en     = 1'b1;
    dout_ready = rdy;
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(dout_valid), 32'(m_valid));
    if (sb_q.size() > 0) begin
      exp_w = sb_q.pop_front();
      check({tag, "_dout"}, 32'(dout), 32'(exp_w));
    end else begin
      check({tag, "_dout_held"}, 32'(dout), 32'(m_dout));
    end
    check({tag, "_busy"}, 32'(busy), 32'(!stop));
    check({tag, "_no_early_pulse"}, 32'({parity_err, frame_err, overrun}), 32'(0));
    @(negedge clk);
    bit_en     = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulses"}, 32'({parity_err, frame_err, overrun}), 32'({e_perr, e_ferr, e_ovr}));
    @(posedge clk); #1;
    check({tag, "_pulse_width"}, 32'({parity_err, frame_err, overrun}), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic accept(input string tag);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    check({tag, "_cleared"}, 32'(dout_valid), 32'(0));
    check({tag, "_dout_kept"}, 32'(dout), 32'(m_dout));
    @(negedge clk);
    dout_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; din = 1'b1; bit_en = 1'b0; dout_ready = 1'b0;
    m_valid = 1'b0; m_dout = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({dout, dout_valid, busy, parity_err, frame_err, overrun}), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame("good_a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    accept("good_accept");

    send_frame("perr_a5", 8'hA5, 1'b1, 1'b1, 1'b0);

    send_frame("ferr_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_bit(1'b0);
      check("break_busy", 32'(busy), 32'(1));
      check("break_no_word", 32'(dout_valid), 32'(0));
    end
    send_bit(1'b1);
    check("break_exit_idle", 32'(busy), 32'(0));
    send_frame("after_break_81", 8'h81, 1'b0, 1'b1, 1'b0);
    accept("after_break_accept");

    send_frame("ovr_first_11", 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame("ovr_second_22", 8'h22, 1'b0, 1'b1, 1'b0);
    send_frame("replace_22", 8'h22, 1'b0, 1'b1, 1'b1);

    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_valid", 32'(dout_valid), 32'(0));
    check("async_rst_dout", 32'(dout), 32'(0));
    m_valid = 1'b0;
    m_dout  = '0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame("post_rst_5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    accept("post_rst_accept");

    send_frame("lsb_pass_a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    check("lsb_first_valid", 32'(lsb_valid), 32'(1));
    check("lsb_first_dout", 32'(lsb_dout), 32'(8'hA5));
    accept("lsb_accept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Framed serial-in, parallel-out receiver; the consuming end of a serial bit stream driven by the team's shift-register transmitters.
- Detects a start bit, shifts in WIDTH data bits, checks optional even parity and stop bit, then presents the word on a valid/ready output.
- Sits between a serial line (din, one sample per bit_en strobe) and a parallel consumer.

Parameters:
- WIDTH, 8, data bits per frame (legal values 2..32).
- MSB_FIRST, 1, 1 = first data bit received is dout[WIDTH-1]; 0 = first data bit is dout[0].
- PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit.

Ports:
- clk  in  1  rising-edge clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- din  in  1  serial line; idle level 1, start bit 0, stop bit 1.
- bit_en  in  1  sample strobe; din is sampled only on clk edges where bit_en=1.
- dout  out  WIDTH  received word; stable while dout_valid=1.
- dout_valid  out  1  word available.
- dout_ready  in  1  consumer accepts the word when dout_valid & dout_ready.
- busy  out  1  high in any state other than IDLE.
- parity_err  out  1  one-cycle pulse; parity mismatch, word discarded.
- frame_err  out  1  one-cycle pulse; stop bit sampled 0, word discarded.
- overrun  out  1  one-cycle pulse; completed word dropped because the output was still full.

Behaviour:
- Reset values: dout=0, dout_valid=0, busy=0, parity_err=0, frame_err=0, overrun=0. FSM enters IDLE; shift register and bit counter are cleared.
- Reset mid-frame aborts the frame with no error pulse. A held output word is lost.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK_WAIT. All transitions occur only on edges with bit_en=1, except for output handshake updates.
- IDLE: bit_en & din=0 -> DATA; bit counter=0; shift register cleared.
- DATA: each bit_en shifts din in, in MSB_FIRST order, and increments the counter. After the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
- PARITY: bit_en samples the parity bit. The expected value is the XOR of the data bits (even parity). Result is held for STOP; -> STOP.
- STOP, bit_en with din=1:
  - Parity bad: pulse parity_err, discard the word, -> IDLE.
  - Parity good: deliver the word, -> IDLE.
- STOP, bit_en with din=0: pulse frame_err, discard the word, -> BREAK_WAIT. Frame error takes priority over parity error; only frame_err pulses.
- BREAK_WAIT: stays until bit_en & din=1, then -> IDLE. A held-low line never produces a false start.
- Delivery latency: dout and dout_valid update on the same clk edge that samples a good stop bit.
- Delivery when dout_valid=0: load dout, set dout_valid.
- Delivery when dout_valid=1 and dout_ready=1 in that cycle: load the new word, keep dout_valid=1, no overrun.
- Delivery when dout_valid=1 and dout_ready=0: keep the old word, pulse overrun, drop the new word.
- Without delivery, dout_valid & dout_ready clears dout_valid at the next edge. dout holds its last value.
- bit_en=0 cycles freeze the FSM, counter and shift register. The handshake still operates.
- Error and overrun pulses are exactly one clk cycle wide, asserted on the edge after the event edge.

Decomposition:
- Package sipo_frame_pkg holds:
  - FSM state encoding for IDLE, DATA, PARITY, STOP, BREAK_WAIT.
  - Constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- One sub-module, sipo_shift_core: WIDTH-bit shift register with shift enable, clear and MSB_FIRST direction, exposing the parallel value and running parity.
- The FSM, counter, output register and handshake stay in sipo_frame_rx.

Test Plan:
- Test plan assumes WIDTH=8, MSB_FIRST=1, PARITY_EN=1, bit_en every 4th cycle.
- Good frame: send 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 -> dout=8'hA5, dout_valid=1 on the stop-sample edge, no error pulses; dout_ready=1 for one cycle -> dout_valid=0.
- Parity error: 0xA5 with parity bit 1 -> parity_err one-cycle pulse, dout_valid stays 0, busy=0 after the stop bit.
- Frame error plus break: 0x3C, parity 0, stop 0, line held 0 for 5 bits then 1 -> frame_err pulse, no new start during the low period, next frame 0x81 received correctly.
- Overrun: dout_ready=0, frames 0x11 then 0x22 -> dout stays 8'h11, overrun pulses once. Repeat with dout_ready=1 on the second stop edge -> dout=8'h22, dout_valid=1, no overrun.
- Reset mid-frame: assert rst after 4 data bits, asynchronously, between edges -> busy=0 and dout_valid=0 immediately; next frame 0x5A received cleanly.
- LSB-first variant, MSB_FIRST=0: serial bits 1,0,1,0,0,1,0,1 -> dout=8'hA5.
